// File: rtl/mac_stop_mult_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_stop_mult_if
// Purpose  : Start/status, A/B memory read port and product result bundle
// Revision : 1.0
// ============================================================================
interface mac_stop_mult_if #(
    parameter int M                      = 3,
    parameter int K                      = 5,
    parameter int N                      = 5,
    parameter int DATA_WIDTH_INIT_MATRIX = 32
);
    localparam int MW = $clog2(M);
    localparam int KW = $clog2(K);
    localparam int NW = $clog2(N);
    localparam int DW = DATA_WIDTH_INIT_MATRIX;

    logic              start;
    logic              matrix_ab_re;
    logic [MW-1:0]     row_addr_a;
    logic [KW-1:0]     col_addr_a;
    logic [KW-1:0]     row_addr_b;
    logic [NW-1:0]     col_addr_b;
    logic [DW-1:0]     data_in_a;
    logic [DW-1:0]     data_in_b;
    logic [2*DW-1:0]   product_reg;
    logic [MW-1:0]     matrix_a_row_addr_counter_reg;
    logic [KW-1:0]     matrix_a_col_addr_counter_reg;
    logic [KW-1:0]     matrix_b_row_addr_counter_reg;
    logic [NW-1:0]     matrix_b_col_addr_counter_reg;
    logic              mult_done_reg;
    logic              mult_last_reg;
    logic              busy;

    modport master (
        input  start, data_in_a, data_in_b,
        output matrix_ab_re, row_addr_a, col_addr_a, row_addr_b, col_addr_b,
        output product_reg, matrix_a_row_addr_counter_reg,
        output matrix_a_col_addr_counter_reg, matrix_b_row_addr_counter_reg,
        output matrix_b_col_addr_counter_reg, mult_done_reg, mult_last_reg, busy
    );

    modport slave (
        output start, data_in_a, data_in_b,
        input  matrix_ab_re, row_addr_a, col_addr_a, row_addr_b, col_addr_b,
        input  product_reg, matrix_a_row_addr_counter_reg,
        input  matrix_a_col_addr_counter_reg, matrix_b_row_addr_counter_reg,
        input  matrix_b_col_addr_counter_reg, mult_done_reg, mult_last_reg, busy
    );
endinterface
`default_nettype wire

// File: rtl/mac_stop_mult.sv
`default_nettype none
// ============================================================================
// Module   : mac_stop_mult
// Purpose  : Streams all A(m,k)*B(k,n) element products of one pass, tagged
// Revision : 1.0
// ============================================================================
module mac_stop_mult #(
    parameter int M                      = 3,
    parameter int K                      = 5,
    parameter int N                      = 5,
    parameter int DATA_WIDTH_INIT_MATRIX = 32
) (
    input  logic             clk,
    input  logic             resetn,
    mac_stop_mult_if.master  bus
);
    localparam int MW = $clog2(M);
    localparam int KW = $clog2(K);
    localparam int NW = $clog2(N);
    localparam int DW = DATA_WIDTH_INIT_MATRIX;

    localparam logic [MW-1:0] C_M_LAST = MW'(M - 1);
    localparam logic [KW-1:0] C_K_LAST = KW'(K - 1);
    localparam logic [NW-1:0] C_N_LAST = NW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    logic [MW-1:0]   r_m;
    logic [NW-1:0]   r_n;
    logic [KW-1:0]   r_k;
    logic            r_drain_cnt;

    logic            r_s1_valid;
    logic            r_s1_last;
    logic [MW-1:0]   r_s1_m;
    logic [NW-1:0]   r_s1_n;
    logic [KW-1:0]   r_s1_k;

    logic [2*DW-1:0] r_product;
    logic [MW-1:0]   r_tag_m;
    logic [KW-1:0]   r_tag_k;
    logic [NW-1:0]   r_tag_n;
    logic            r_done;
    logic            r_last;

    logic            w_run;
    logic            w_issue_last;
    logic [2*DW-1:0] w_product;

    assign w_run        = (r_state == RUN);
    assign w_issue_last = w_run && (r_m == C_M_LAST) && (r_n == C_N_LAST) && (r_k == C_K_LAST);
    assign w_product    = {{DW{1'b0}}, bus.data_in_a} * {{DW{1'b0}}, bus.data_in_b};

    // Addresses are zeroed whenever no read is being issued
    assign bus.matrix_ab_re = w_run;
    assign bus.row_addr_a   = w_run ? r_m : '0;
    assign bus.col_addr_a   = w_run ? r_k : '0;
    assign bus.row_addr_b   = w_run ? r_k : '0;
    assign bus.col_addr_b   = w_run ? r_n : '0;
    assign bus.busy         = (r_state != IDLE);

    assign bus.product_reg                   = r_product;
    assign bus.matrix_a_row_addr_counter_reg = r_tag_m;
    assign bus.matrix_a_col_addr_counter_reg = r_tag_k;
    assign bus.matrix_b_row_addr_counter_reg = r_tag_k;
    assign bus.matrix_b_col_addr_counter_reg = r_tag_n;
    assign bus.mult_done_reg                 = r_done;
    assign bus.mult_last_reg                 = r_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_m         <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_drain_cnt <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_m     <= '0;
                        r_n     <= '0;
                        r_k     <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // k innermost, then n, then m
                    if (r_k == C_K_LAST) begin
                        r_k <= '0;
                        if (r_n == C_N_LAST) begin
                            r_n <= '0;
                            r_m <= r_m + 1'b1;
                        end else begin
                            r_n <= r_n + 1'b1;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                    if (w_issue_last) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt) begin
                        r_state <= IDLE;
                    end else begin
                        r_drain_cnt <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Stage 1 aligns the issued tags with the one-cycle memory latency
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_m     <= '0;
            r_s1_n     <= '0;
            r_s1_k     <= '0;
            r_product  <= '0;
            r_tag_m    <= '0;
            r_tag_k    <= '0;
            r_tag_n    <= '0;
            r_done     <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_s1_valid <= w_run;
            r_s1_last  <= w_issue_last;
            r_s1_m     <= r_m;
            r_s1_n     <= r_n;
            r_s1_k     <= r_k;
            r_done     <= r_s1_valid;
            r_last     <= r_s1_valid & r_s1_last;
            if (r_s1_valid) begin
                r_product <= w_product;
                r_tag_m   <= r_s1_m;
                r_tag_k   <= r_s1_k;
                r_tag_n   <= r_s1_n;
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/mac_stop_mult.md
MAC_STOP_MULT -- requirements
Module: mac_stop_mult

Interface
REQ-001 SHALL have parameters: M, default 3, rows of A/C; K, default 5, cols of A/rows of B; N, default 5, cols of B/C; DATA_WIDTH_INIT_MATRIX, default 32, element width of A and B. Legal values: M, K, N >= 2.
REQ-002 SHALL have ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  begin one A x B product pass.
- matrix_ab_re  out  1  read enable for the A and B memories.
- row_addr_a  out  $clog2(M)  A read row.
- col_addr_a  out  $clog2(K)  A read column.
- row_addr_b  out  $clog2(K)  B read row.
- col_addr_b  out  $clog2(N)  B read column.
- data_in_a  in  DATA_WIDTH_INIT_MATRIX  A element; valid one cycle after a read.
- data_in_b  in  DATA_WIDTH_INIT_MATRIX  B element; valid one cycle after a read.
- product_reg  out  2*DATA_WIDTH_INIT_MATRIX  registered product.
- matrix_a_row_addr_counter_reg  out  $clog2(M)  m tag of product_reg.
- matrix_a_col_addr_counter_reg  out  $clog2(K)  k tag of product_reg.
- matrix_b_row_addr_counter_reg  out  $clog2(K)  k tag of product_reg.
- matrix_b_col_addr_counter_reg  out  $clog2(N)  n tag of product_reg.
- mult_done_reg  out  1  product_reg and tags valid this cycle.
- mult_last_reg  out  1  final product of the pass.
- busy  out  1  pass in progress.

Function
REQ-003 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-004 IDLE: start=1 at an edge SHALL clear counters m, n, k to 0 and enter RUN.
REQ-005 RUN: matrix_ab_re SHALL be 1 every cycle, with row_addr_a=m, col_addr_a=k, row_addr_b=k, col_addr_b=n (driven combinationally from the counters).
REQ-006 Counter order SHALL be m outermost, n middle, k innermost, each ascending:
- k wraps K-1 -> 0 and increments n;
- n wraps N-1 -> 0 and increments m.
REQ-007 When m=M-1, n=N-1, k=K-1 is issued, FSM SHALL enter DRAIN. Exactly M*N*K reads per pass.
REQ-008 Stage 1 SHALL delay the issued (m, n, k) and a valid bit by one cycle, aligned with data_in_a and data_in_b.
REQ-009 Stage 2 SHALL register:
- product_reg <= data_in_a * data_in_b, unsigned, full 2*DATA_WIDTH_INIT_MATRIX bits, no truncation or saturation;
- the four tag outputs <= the stage-1 delayed m, k, k, n;
- mult_done_reg <= the stage-1 valid bit.
REQ-010 Latency SHALL be 2 cycles from address issue to mult_done_reg=1 with matching tags. Throughput SHALL be one product per cycle, no bubbles within a pass.
REQ-011 mult_last_reg SHALL be 1 only in the cycle carrying product (M-1, N-1, K-1), and 0 otherwise.
REQ-012 DRAIN SHALL last 2 cycles, then return to IDLE. busy SHALL be 1 in RUN and DRAIN, and 0 in IDLE.
REQ-013 start in RUN or DRAIN SHALL be ignored, with no restart and no queuing.
REQ-014 start held high SHALL launch a new pass on the first edge in IDLE after DRAIN.
REQ-015 When mult_done_reg=0, product_reg and the tags SHALL hold their last values.
REQ-016 matrix_ab_re SHALL be 0 outside RUN. Address outputs SHALL be 0 in IDLE.

Reset
REQ-017 resetn=0 SHALL immediately and asynchronously clear all state and outputs to 0 and force IDLE.
REQ-018 A reset mid-pass SHALL discard in-flight products; no mult_done_reg pulse SHALL follow reset release.
REQ-019 The first start after reset release SHALL begin a fresh pass at (0,0,0).

Verification
REQ-020 Test 2x2x2: A=[[1,2],[3,4]], B=[[5,6],[7,8]], start pulse -> mult_done_reg high for 8 consecutive cycles, starting 2 cycles after the first read.
- product_reg sequence SHALL be 5, 14, 6, 16, 15, 28, 18, 32.
- Tags (m,n,k) SHALL be (0,0,0), (0,0,1), (0,1,0), (0,1,1), (1,0,0), (1,0,1), (1,1,0), (1,1,1).
- mult_last_reg=1 only with 32.
REQ-021 Test width, DATA_WIDTH_INIT_MATRIX=32, all elements 32'hFFFFFFFF -> every product_reg = 64'hFFFFFFFE00000001.
REQ-022 Test count, M=3, K=5, N=5 -> exactly 75 mult_done_reg pulses, then busy=0 two cycles after the last read.
REQ-023 Test start while busy, start pulsed during RUN and during DRAIN -> 75 pulses total, no restart.
REQ-024 Test reset mid-run, resetn=0 after the 10th read -> all outputs 0 at once; no pulses after release; the next start issues address (0,0,0).
REQ-025 Test back-to-back, start held high -> second pass begins in the first IDLE cycle after DRAIN; tag sequence restarts at (0,0,0).
